// File: rtl/xpb_pkg.sv
// Shared constants and FSM state type for the xpb table generator.
package xpb_pkg;

    localparam int XPB_WIDTH     = 1024;
    localparam int XPB_ADDR_BITS = 5;

    typedef enum logic [1:0] {
        IDLE,
        BASE,
        FILL,
        DONE
    } xpb_state_e;

endpackage

// File: rtl/xpb_table_gen_if.sv
// Valid/ready write port from the table generator into the xpb RAM.
interface xpb_table_gen_if
    import xpb_pkg::*;
#(
    parameter int WIDTH     = XPB_WIDTH,
    parameter int ADDR_BITS = XPB_ADDR_BITS
);
    logic                 wr_valid;
    logic                 wr_ready;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [WIDTH-1:0]     wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/xpb_mod_add.sv
// (a+b) mod m for a,b < m: one conditional subtract on a WIDTH+1 bit sum.
module xpb_mod_add #(
    parameter int WIDTH = 1024
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] y_o
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] red;
    logic [WIDTH:0] mx;

    always_comb begin
        mx  = {1'b0, m_i};
        sum = {1'b0, a_i} + {1'b0, b_i};
        red = (sum >= mx) ? (sum - mx) : sum;
        y_o = red[WIDTH-1:0];
    end
endmodule

// File: rtl/xpb_table_gen.sv
// Generates E[j] = (j * 2^shift) mod M and streams it into the xpb RAM.
module xpb_table_gen
    import xpb_pkg::*;
#(
    parameter int WIDTH      = XPB_WIDTH,
    parameter int ADDR_BITS  = XPB_ADDR_BITS,
    parameter int SHIFT_BITS = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      modulus,
    input  logic [SHIFT_BITS-1:0] shift,
    output logic                  busy,
    output logic                  done,
    xpb_table_gen_if.master       wr
);
    localparam logic [ADDR_BITS-1:0]  LAST = '1;
    localparam logic [SHIFT_BITS-1:0] ONE  = SHIFT_BITS'(1);

    xpb_state_e            state_q, state_d;
    logic [WIDTH-1:0]      m_q;
    logic [WIDTH-1:0]      r_q;
    logic [WIDTH-1:0]      base_q;
    logic [WIDTH-1:0]      acc_q;
    logic [SHIFT_BITS-1:0] cnt_q;
    logic [ADDR_BITS-1:0]  j_q;
    logic [WIDTH-1:0]      add_a, add_b, sum;

    // BASE doubles r, FILL steps acc by base: one shared adder.
    assign add_a = (state_q == BASE) ? r_q : acc_q;
    assign add_b = (state_q == BASE) ? r_q : base_q;

    xpb_mod_add #(.WIDTH(WIDTH)) u_add (
        .a_i (add_a),
        .b_i (add_b),
        .m_i (m_q),
        .y_o (sum)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = (shift == '0) ? FILL : BASE;
            BASE: if (cnt_q == ONE) state_d = FILL;
            FILL: if (wr.wr_ready && j_q == LAST) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q == BASE) || (state_q == FILL);
        done        = (state_q == DONE);
        wr.wr_valid = (state_q == FILL);
        wr.wr_addr  = (state_q == FILL) ? j_q : '0;
        wr.wr_data  = (state_q == FILL) ? acc_q : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_q    <= '0;
            r_q    <= '0;
            base_q <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            j_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (start) begin
                    m_q    <= modulus;
                    cnt_q  <= shift;
                    r_q    <= WIDTH'(1);
                    base_q <= WIDTH'(1);
                    acc_q  <= '0;
                    j_q    <= '0;
                end
                BASE: begin
                    r_q   <= sum;
                    cnt_q <= cnt_q - ONE;
                    if (cnt_q == ONE) base_q <= sum;
                end
                FILL: if (wr.wr_ready) begin
                    acc_q <= sum;
                    j_q   <= j_q + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
